// File: rtl/axis_udp_port_filter.sv
// AXI4-Stream UDP destination-port filter with a one-stage registered egress.
// Optional frame counters (pkt_pass_cnt/pkt_drop_cnt) are built when UDP_FILTER_STATS_EN is defined.
module axis_udp_port_filter #(
   parameter int unsigned AXIS_DATA_WIDTH  = 512,
   parameter int unsigned AXIS_TUSER_WIDTH = 256
) (
   input  logic                            axis_aclk,
   input  logic                            axis_resetn,
   input  logic [15:0]                     DEST_PORT_NUM,
   input  logic [AXIS_DATA_WIDTH-1:0]      s_axis_tdata,
   input  logic [AXIS_DATA_WIDTH/8-1:0]    s_axis_tkeep,
   input  logic [AXIS_TUSER_WIDTH-1:0]     s_axis_tuser,
   input  logic                            s_axis_tvalid,
   output logic                            s_axis_tready,
   input  logic                            s_axis_tlast,
   output logic [AXIS_DATA_WIDTH-1:0]      m_axis_tdata,
   output logic [AXIS_DATA_WIDTH/8-1:0]    m_axis_tkeep,
   output logic [AXIS_TUSER_WIDTH-1:0]     m_axis_tuser,
   output logic                            m_axis_tvalid,
   input  logic                            m_axis_tready,
   output logic                            m_axis_tlast
`ifdef UDP_FILTER_STATS_EN
   ,
   output logic [31:0]                     pkt_pass_cnt,
   output logic [31:0]                     pkt_drop_cnt
`endif
);

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_PASS,
      ST_DROP
   } state_t;

   state_t                          r_state;
   state_t                          w_state_nxt;
   logic [AXIS_DATA_WIDTH-1:0]      r_m_tdata;
   logic [AXIS_DATA_WIDTH/8-1:0]    r_m_tkeep;
   logic [AXIS_TUSER_WIDTH-1:0]     r_m_tuser;
   logic                            r_m_tvalid;
   logic                            r_m_tlast;

   logic                            w_out_free;
   logic                            w_s_ready;
   logic                            w_accept;
   logic                            w_match;
   logic                            w_fwd;
   logic [15:0]                     w_ethertype;
   logic [15:0]                     w_dst_port;

   // Header fields of beat 0: byte n sits at tdata[8n+7:8n], multi-byte fields are big-endian.
   assign w_ethertype = {s_axis_tdata[12*8 +: 8], s_axis_tdata[13*8 +: 8]};
   assign w_dst_port  = {s_axis_tdata[36*8 +: 8], s_axis_tdata[37*8 +: 8]};
   assign w_match     = (w_ethertype == 16'h0800) &&
                        (s_axis_tdata[14*8 +: 8] == 8'h45) &&
                        (s_axis_tdata[23*8 +: 8] == 8'h11) &&
                        (w_dst_port == DEST_PORT_NUM) &&
                        (s_axis_tkeep[37:0] == '1);

   assign w_out_free = !r_m_tvalid || m_axis_tready;
   assign w_accept   = s_axis_tvalid && w_s_ready;

   always_comb begin
      w_state_nxt = r_state;
      w_s_ready   = w_out_free;
      w_fwd       = 1'b0;
      case (r_state)
         ST_IDLE: begin
            if (w_accept) begin
               w_fwd = w_match;
               if (!s_axis_tlast) begin
                  w_state_nxt = w_match ? ST_PASS : ST_DROP;
               end
            end
         end
         ST_PASS: begin
            w_fwd = w_accept;
            if (w_accept && s_axis_tlast) begin
               w_state_nxt = ST_IDLE;
            end
         end
         ST_DROP: begin
            // Discarded beats never touch the egress register, so drain unconditionally.
            w_s_ready = 1'b1;
            if (w_accept && s_axis_tlast) begin
               w_state_nxt = ST_IDLE;
            end
         end
         default: begin
            w_state_nxt = ST_IDLE;
         end
      endcase
   end

   always_ff @(posedge axis_aclk or negedge axis_resetn) begin
      if (!axis_resetn) begin
         r_state <= ST_IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   always_ff @(posedge axis_aclk or negedge axis_resetn) begin
      if (!axis_resetn) begin
         r_m_tvalid <= 1'b0;
         r_m_tlast  <= 1'b0;
         r_m_tdata  <= '0;
         r_m_tkeep  <= '0;
         r_m_tuser  <= '0;
      end else if (w_fwd) begin
         r_m_tvalid <= 1'b1;
         r_m_tlast  <= s_axis_tlast;
         r_m_tdata  <= s_axis_tdata;
         r_m_tkeep  <= s_axis_tkeep;
         r_m_tuser  <= s_axis_tuser;
      end else if (w_out_free) begin
         r_m_tvalid <= 1'b0;
      end
   end

   assign s_axis_tready = w_s_ready;
   assign m_axis_tdata  = r_m_tdata;
   assign m_axis_tkeep  = r_m_tkeep;
   assign m_axis_tuser  = r_m_tuser;
   assign m_axis_tvalid = r_m_tvalid;
   assign m_axis_tlast  = r_m_tlast;

`ifdef UDP_FILTER_STATS_EN
   logic [31:0] r_pass_cnt;
   logic [31:0] r_drop_cnt;

   always_ff @(posedge axis_aclk or negedge axis_resetn) begin
      if (!axis_resetn) begin
         r_pass_cnt <= '0;
         r_drop_cnt <= '0;
      end else if (r_state == ST_IDLE && w_accept) begin
         if (w_match) begin
            r_pass_cnt <= r_pass_cnt + 32'd1;
         end else begin
            r_drop_cnt <= r_drop_cnt + 32'd1;
         end
      end
   end

   assign pkt_pass_cnt = r_pass_cnt;
   assign pkt_drop_cnt = r_drop_cnt;
`endif

endmodule
